// File: rtl/conv5x5_pe.sv
// ---------------------------------------------------------------------------
// conv5x5_pe -- single-kernel 5x5 convolution processing element.
//
// Holds a 25-entry input window, 25 kernel weights and a bias, all written
// by the upstream controller through indexed strobes. On start it runs a
// serial multiply-accumulate (one tap per cycle), adds the bias, rescales
// from the doubled fixed-point format, saturates and presents one result.
//
// Optional build macro: CONV5X5_PE_RELU_EN -- clamps negative results to 0.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   data_en_i       write data_in_i to window[data_idx_i] (idx 0..24)
//   data_idx_i      window index, row-major (5*row+col)
//   data_in_i       signed pixel / feature value
//   weight_en_i     write weight_in_i to weight[weight_idx_i] (25 = bias)
//   weight_idx_i    weight index 0..24, 25 selects the bias
//   weight_in_i     signed weight or bias
//   update_i        shift window one column left (column 4 keeps its value)
//   start_i         begin a convolution on the current window
//   busy_o          high whenever the PE is not idle
//   out_valid_o     one-cycle pulse when out_data_o is new
//   out_data_o      signed result, held until the next result
// ---------------------------------------------------------------------------
module conv5x5_pe #(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16,
  parameter int ACC_W  = 2*DATA_W+5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_en_i,
  input  logic [4:0]        data_idx_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              weight_en_i,
  input  logic [4:0]        weight_idx_i,
  input  logic [DATA_W-1:0] weight_in_i,
  input  logic              update_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  localparam int NTAP   = 25;
  localparam int PROD_W = 2*DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_BIAS = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [4:0]                  idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [NTAP-1:0][DATA_W-1:0] win_q, win_d;
  logic [NTAP-1:0][DATA_W-1:0] wgt_q, wgt_d;
  logic [DATA_W-1:0]           bias_q, bias_d;
  logic [DATA_W-1:0]           out_q, out_d;
  logic                        vld_q, vld_d;

  logic                        idle;
  assign idle = (state_q == S_IDLE);

  // Window with every row shifted one column left; column 4 is retained.
  logic [NTAP-1:0][DATA_W-1:0] win_shift;
  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < 5; c++) begin : g_col
      if (c < 4) begin : g_mv
        assign win_shift[5*r+c] = win_q[5*r+c+1];
      end else begin : g_keep
        assign win_shift[5*r+c] = win_q[5*r+c];
      end
    end
  end

  // Full-width signed product of the current tap, sign-extended to ACC_W.
  logic [DATA_W-1:0]       tap_x, tap_w;
  logic signed [PROD_W-1:0] tap_x_ext, tap_w_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext;
  assign tap_x     = win_q[idx_q];
  assign tap_w     = wgt_q[idx_q];
  assign tap_x_ext = {{DATA_W{tap_x[DATA_W-1]}}, tap_x};
  assign tap_w_ext = {{DATA_W{tap_w[DATA_W-1]}}, tap_w};
  assign prod      = tap_x_ext * tap_w_ext;
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Bias is aligned to the product scale (2*FRAC fractional bits), then the
  // sum is rescaled by an arithmetic right shift, which floors.
  logic signed [ACC_W-1:0] bias_ext, bias_sh, sum, shr;
  logic [ACC_W-DATA_W:0]   top;
  logic [DATA_W-1:0]       sat, res;
  assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
  assign bias_sh  = bias_ext <<< FRAC;
  assign sum      = acc_q + bias_sh;
  assign shr      = sum >>> FRAC;
  // In range iff every bit above the result's sign bit matches it.
  assign top      = shr[ACC_W-1:DATA_W-1];

  always_comb begin
    if ((&top) || !(|top)) sat = shr[DATA_W-1:0];
    else if (shr[ACC_W-1]) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                   sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

`ifdef CONV5X5_PE_RELU_EN
  assign res = sat[DATA_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    win_d   = win_q;
    wgt_d   = wgt_q;
    bias_d  = bias_q;
    out_d   = out_q;
    vld_d   = 1'b0;

    // Loads only land while idle; window and weights freeze during a run.
    if (idle) begin
      if (update_i) win_d = win_shift;
      // Write after the shift so a new column-4 pixel can ride the update.
      if (data_en_i && (data_idx_i < 5'd25)) win_d[data_idx_i] = data_in_i;
      if (weight_en_i) begin
        if (weight_idx_i < 5'd25)       wgt_d[weight_idx_i] = weight_in_i;
        else if (weight_idx_i == 5'd25) bias_d = weight_in_i;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd24) state_d = S_BIAS;
      end
      S_BIAS: begin
        out_d   = res;
        vld_d   = 1'b1;
        state_d = S_OUT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      win_q   <= '0;
      wgt_q   <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      wgt_q   <= wgt_d;
      bias_q  <= bias_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign busy_o      = !idle;
  assign out_valid_o = vld_q;
  assign out_data_o  = out_q;

endmodule

// File: tb/tb_conv5x5_pe.sv
// ---------------------------------------------------------------------------
// Bench for conv5x5_pe: table of whole-kernel cases, hand sequences for the
// sliding window, mid-run reset and busy-time lockout, then random loads
// compared against a plain-arithmetic convolution model.
// ---------------------------------------------------------------------------
module tb_conv5x5_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_en, weight_en, update, start;
  logic [4:0]  data_idx, weight_idx;
  logic [31:0] data_in, weight_in;
  logic        busy, out_valid;
  logic [31:0] out_data;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: what the PE should currently hold.
  logic [31:0] mw[25];
  logic [31:0] mk[25];
  logic [31:0] mb;

  conv5x5_pe #(.DATA_W(32), .FRAC(16)) dut (
    .clk(clk), .reset(reset),
    .data_en_i(data_en), .data_idx_i(data_idx), .data_in_i(data_in),
    .weight_en_i(weight_en), .weight_idx_i(weight_idx), .weight_in_i(weight_in),
    .update_i(update), .start_i(start),
    .busy_o(busy), .out_valid_o(out_valid), .out_data_o(out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 25; k++) begin mw[k] = '0; mk[k] = '0; end
    mb = '0;
  endfunction

  // Convolution straight from the arithmetic definition, on wide integers.
  function automatic logic [31:0] model_out();
    logic signed [127:0] acc;
    logic [31:0] r;
    longint maxv, minv;
    maxv = (longint'(1) <<< 31) - 1;
    minv = -(longint'(1) <<< 31);
    acc = 0;
    for (int k = 0; k < 25; k++)
      acc += longint'($signed(mw[k])) * longint'($signed(mk[k]));
    acc += longint'($signed(mb)) * 65536;
    acc = acc >>> 16;
    if (acc > maxv)      r = 32'h7FFF_FFFF;
    else if (acc < minv) r = 32'h8000_0000;
    else                 r = acc[31:0];
`ifdef CONV5X5_PE_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  task automatic idle_inputs();
    data_en = 0; weight_en = 0; update = 0; start = 0;
    data_idx = 0; weight_idx = 0; data_in = 0; weight_in = 0;
  endtask

  // One idle cycle of loads; the model mirrors the documented load rules.
  task automatic drive(input bit de, input logic [4:0] di, input logic [31:0] dv,
                       input bit we, input logic [4:0] wi, input logic [31:0] wv,
                       input bit up);
    data_en = de; data_idx = di; data_in = dv;
    weight_en = we; weight_idx = wi; weight_in = wv;
    update = up;
    tick();
    idle_inputs();
    if (up) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 4; c++) mw[5*r+c] = mw[5*r+c+1];
    end
    if (de && di < 25) mw[di] = dv;
    if (we && wi < 25) mk[wi] = wv;
    else if (we && wi == 25) mb = wv;
  endtask

  task automatic load_all(input logic [31:0] wv, input logic [31:0] kv, input logic [31:0] bv);
    for (int k = 0; k < 25; k++) drive(1, 5'(k), wv, 1, 5'(k), kv, 0);
    drive(0, 0, 0, 1, 5'd25, bv, 0);
  endtask

  // Start, then watch 28 cycles: busy over 1..27, valid only at 27, result
  // at 27 and still held at 28. Optional lockout stimulus at cycle 3.
  task automatic run_conv(input string name, input bit inject,
                          input bit use_tab, input logic [31:0] tab_exp);
    logic [31:0] exp, got;
    bit busy_ok, vld_ok;
    int pulses;
    exp = model_out();
    busy_ok = 1; vld_ok = 1; pulses = 0; got = 'x;
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 28; k++) begin
      if (busy !== (k <= 27)) busy_ok = 0;
      if (out_valid !== (k == 27)) vld_ok = 0;
      if (out_valid === 1'b1) pulses++;
      if (k == 27) got = out_data;
      if (k == 28) chk({name, " held"}, out_data, got);
      data_en = 0; weight_en = 0; start = 0;
      if (inject && k == 3) begin
        start = 1;
        data_en = 1; data_idx = 0; data_in = 32'h0005_0000;
        weight_en = 1; weight_idx = 0; weight_in = 32'h0005_0000;
      end
      if (k < 28) tick();
    end
    idle_inputs();
    chk({name, " busy window"}, 32'(busy_ok), 32'd1);
    chk({name, " valid window"}, 32'(vld_ok), 32'd1);
    chk({name, " pulses"}, 32'(pulses), 32'd1);
    chk({name, " model"}, got, exp);
    if (use_tab) chk({name, " table"}, got, tab_exp);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    if ($urandom_range(0, 7) == 0) v = $urandom;
    else v = 32'($urandom_range(0, 32'h001F_FFFF)) - 32'h0010_0000;
    return v;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] wv, kv, bv, exp;
  } vec_t;

  initial begin
    vec_t tab[5];
    int   nc;

    tab[0] = '{"ones",     32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0019_0000};
`ifdef CONV5X5_PE_RELU_EN
    tab[1] = '{"negbias",  32'h0001_0000, 32'h0001_0000, 32'hFFE2_0000, 32'h0000_0000};
    tab[3] = '{"sat_neg",  32'h7FFF_0000, 32'h8001_0000, 32'h7FFF_0000, 32'h0000_0000};
`else
    tab[1] = '{"negbias",  32'h0001_0000, 32'h0001_0000, 32'hFFE2_0000, 32'hFFFB_0000};
    tab[3] = '{"sat_neg",  32'h7FFF_0000, 32'h8001_0000, 32'h7FFF_0000, 32'h8000_0000};
`endif
    tab[2] = '{"sat_pos",  32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF};
    tab[4] = '{"half",     32'h0000_8000, 32'h0000_8000, 32'hFFFF_0000, 32'h0005_4000};

    idle_inputs();
    model_clear();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset data", out_data, 32'd0);

    for (int i = 0; i < 5; i++) begin
      load_all(tab[i].wv, tab[i].kv, tab[i].bv);
      run_conv(tab[i].name, 0, 1, tab[i].exp);
    end

    // Sliding window: window[k]=k, only tap 3 weighted.
    for (int k = 0; k < 25; k++)
      drive(1, 5'(k), 32'(k) << 16, 1, 5'(k), (k == 3) ? 32'h0001_0000 : 32'h0, 0);
    drive(0, 0, 0, 1, 5'd25, 32'h0, 0);
    run_conv("tap3", 0, 1, 32'h0003_0000);
    drive(0, 0, 0, 0, 0, 0, 1);
    run_conv("shift", 0, 1, 32'h0004_0000);
    drive(1, 5'd4, 32'h0064_0000, 1, 5'd3, 32'h0, 1);
    drive(0, 0, 0, 1, 5'd4, 32'h0001_0000, 0);
    run_conv("shift+write", 0, 1, 32'h0064_0000);

    // Mid-run reset: bias made nonzero first so the cleared state shows.
    drive(0, 0, 0, 1, 5'd25, 32'h0007_0000, 0);
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1;
    tick();
    reset = 0;
    model_clear();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort data", out_data, 32'd0);
    nc = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid === 1'b1) nc++;
      tick();
    end
    chk("abort no valid", 32'(nc), 32'd0);
    run_conv("after reset", 0, 1, 32'h0000_0000);

    // Lockout while busy.
    load_all(32'h0001_0000, 32'h0001_0000, 32'h0);
    run_conv("lockout", 1, 1, 32'h0019_0000);
    run_conv("lockout rerun", 0, 1, 32'h0019_0000);

    // Random loads, including out-of-range indices and update+write pairs.
    for (int it = 0; it < 25; it++) begin
      nc = $urandom_range(5, 40);
      for (int c = 0; c < nc; c++)
        drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), rnd_val(),
              $urandom_range(0, 1), 5'($urandom_range(0, 31)), rnd_val(),
              $urandom_range(0, 3) == 0);
      run_conv($sformatf("rand%0d", it), 0, 0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
